// File: rtl/mult_pkg.sv
// Shared definitions for the 8-slot 8x8 multiplier array back end.
package mult_pkg;

  localparam int PP_W     = 16;
  localparam int NUM_MULT = 8;
  localparam int RES_W    = 64;

  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } asm_state_e;

  // Place one slot product at a byte-granular weight inside the 64-bit result.
  function automatic logic [RES_W-1:0] slot_term(input logic [PP_W-1:0] pp,
                                                 input int byteShift);
    return RES_W'(pp) << (8 * byteShift);
  endfunction

endpackage

// File: rtl/pp_shift_sum.sv
// Combinational recombination of the eight slot products for one pass.
// 8-bit lanes pass slots 0..3 straight through, 16-bit lanes combine four
// slots each, and a 32-bit pass weights every slot by 8*(i+j).
module pp_shift_sum
  import mult_pkg::*;
(
  input  logic [NUM_MULT*PP_W-1:0] i_pp,
  input  logic [1:0]               i_sew,
  input  logic                     i_pass,
  output logic [RES_W-1:0]         o_sum
);

  logic [PP_W-1:0] w_pp [NUM_MULT];

  for (genvar k = 0; k < NUM_MULT; k++) begin : g_slot
    assign w_pp[k] = i_pp[PP_W*k +: PP_W];
  end

  // Weighted sum selected by element width; pass 1 moves B bytes up by two.
  always_comb begin
    o_sum = '0;
    case (sew_e'(i_sew))
      SEW_8: begin
        o_sum = {w_pp[3], w_pp[2], w_pp[1], w_pp[0]};
      end
      SEW_16: begin
        for (int j = 0; j < 2; j++) begin
          o_sum[32*j +: 32] = 32'(w_pp[4*j])
                            + ((32'(w_pp[4*j+1]) + 32'(w_pp[4*j+2])) << 8)
                            + (32'(w_pp[4*j+3]) << 16);
        end
      end
      SEW_32: begin
        for (int s = 0; s < NUM_MULT; s++) begin
          o_sum = o_sum + slot_term(w_pp[s], (s % 4) + (s / 4) + (i_pass ? 2 : 0));
        end
      end
      default: begin
        o_sum = '0;
      end
    endcase
  end

endmodule

// File: rtl/product_assembler_8.sv
// Back end of the 8-slot multiplier array: turns slot products into element
// products. 8/16-bit elements finish in one pass; 32-bit elements need a
// pass-0 / pass-1 pair, with pass 0 parked in an accumulator until pass 1.
// Optional feature macro: PROD_ASM_ERR_EN adds the 'err' protocol-error pulse.
module product_assembler_8 #(
  parameter int PP_W     = mult_pkg::PP_W,
  parameter int NUM_MULT = mult_pkg::NUM_MULT,
  parameter int RES_W    = mult_pkg::RES_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NUM_MULT*PP_W-1:0] pp_in,
  input  logic [1:0]               sew,
  input  logic                     count_0,
  output logic [RES_W-1:0]         result,
  output logic                     out_valid
`ifdef PROD_ASM_ERR_EN
  ,
  output logic                     err
`endif
);

  import mult_pkg::*;

  asm_state_e       r_state;
  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] r_result;
  logic             r_outValid;
  logic [RES_W-1:0] w_sum;
  sew_e             w_sew;

  assign w_sew = sew_e'(sew);

  pp_shift_sum u_sum (
    .i_pp   (pp_in),
    .i_sew  (sew),
    .i_pass (count_0),
    .o_sum  (w_sum)
  );

  // Pass sequencing, accumulator and registered result / valid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_result   <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (in_valid) begin
        case (w_sew)
          SEW_8, SEW_16: begin
            r_result   <= w_sum;
            r_outValid <= 1'b1;
            r_acc      <= '0;
            r_state    <= IDLE;
          end
          SEW_32: begin
            if (!count_0) begin
              r_acc   <= w_sum;
              r_state <= HALF;
            end else if (r_state == HALF) begin
              r_result   <= r_acc + w_sum;
              r_outValid <= 1'b1;
              r_acc      <= '0;
              r_state    <= IDLE;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_outValid;

`ifdef PROD_ASM_ERR_EN
  logic w_errEvent;
  logic r_err;

  // Protocol violations: orphan pass 1, pass-0 overwrite, abandoned half, reserved sew.
  always_comb begin
    w_errEvent = 1'b0;
    if (in_valid) begin
      case (w_sew)
        SEW_8, SEW_16: w_errEvent = (r_state == HALF);
        SEW_32:        w_errEvent = count_0 ? (r_state == IDLE) : (r_state == HALF);
        default:       w_errEvent = 1'b1;
      endcase
    end
  end

  // Register the error so it lines up with the out_valid timing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_errEvent;
    end
  end

  assign err = r_err;
`endif

endmodule
